// File: rtl/seq_pkg.sv
// seq_pkg: shared state/mode encodings and index sizing for the LED sequencer.
package seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  typedef enum logic [1:0] {MODE_WALK, MODE_COUNT, MODE_PINGPONG, MODE_BLINK} mode_t;
  localparam int SEQ_STEPS = 8;
  localparam int IDX_W = 3;
endpackage

// File: rtl/pattern_rom.sv
// pattern_rom: combinational ring pattern for a given mode and step index.
module pattern_rom
  import seq_pkg::*;
(
  input  mode_t            mode,
  input  logic [IDX_W-1:0] idx,
  output logic [3:0]       pat
);
  logic [3:0] pp;
  always_comb begin
    pp  = idx[2] ? (4'b1000 >> idx[1:0]) : (4'b0001 << idx[1:0]);
    pat = mode == MODE_WALK     ? 4'b0001 << idx[1:0] :
          mode == MODE_COUNT    ? {1'b0, idx} :
          mode == MODE_PINGPONG ? pp : {4{~idx[0]}};
  end
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: run/pause/step FSM stepping a 4-LED ring pattern plus heartbeat.
module led_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_PASSES = 3,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              run_toggle,
  input  logic              step,
  input  logic              clear,
  input  logic              dir,
  input  logic [1:0]        mode,
  output logic [4:0]        leds,
  output logic [IDX_W-1:0]  step_idx,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              running,
  output logic              done
);
  localparam logic [PASS_W-1:0] LAST = PASS_W'(NUM_PASSES);
  localparam logic [PASS_W-1:0] SAT = '1;
  state_t state;
  mode_t mode_q, rom_mode;
  logic start, adv, wrap, fin;
  logic [IDX_W-1:0] nidx, rom_idx;
  logic [3:0] pat;
  // The ROM looks at the next index (or index 0 of the new mode on start) so leds stay registered.
  always_comb begin
    start    = run_toggle && (state == IDLE || state == DONE);
    adv      = (state == RUN && tick) || (state == PAUSE && step);
    nidx     = dir ? step_idx + 1'b1 : step_idx - 1'b1;
    wrap     = dir ? step_idx == IDX_W'(SEQ_STEPS - 1) : step_idx == '0;
    fin      = wrap && NUM_PASSES != 0 && pass_cnt + 1'b1 == LAST;
    rom_mode = start ? mode_t'(mode) : mode_q;
    rom_idx  = start ? '0 : nidx;
  end
  pattern_rom u_rom (.mode(rom_mode), .idx(rom_idx), .pat(pat));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= MODE_WALK;
      step_idx <= '0;
      pass_cnt <= '0;
      leds <= '0;
      running <= 1'b0;
      done <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      mode_q <= MODE_WALK;
      step_idx <= '0;
      pass_cnt <= '0;
      leds <= '0;
      running <= 1'b0;
      done <= 1'b0;
    end else if (run_toggle) begin
      if (start) begin
        mode_q <= mode_t'(mode);
        step_idx <= '0;
        pass_cnt <= '0;
        leds <= {1'b0, pat};
      end
      state <= state == RUN ? PAUSE : RUN;
      running <= state != RUN;
      done <= 1'b0;
    end else if (adv) begin
      if (fin) begin
        state <= DONE;
        pass_cnt <= LAST;
        leds[4] <= 1'b1;
        running <= 1'b0;
        done <= 1'b1;
      end else begin
        step_idx <= nidx;
        leds <= {~leds[4], pat};
        if (wrap && pass_cnt != SAT) pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench for led_sequencer with NUM_PASSES = 3.
module tb_led_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic tick = 1'b0, run_toggle = 1'b0, step = 1'b0, clear = 1'b0, dir = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [4:0] leds;
  logic [2:0] step_idx;
  logic [3:0] pass_cnt;
  logic running, done;
  logic [13:0] sb[$];
  logic [13:0] e;
  int vecs = 0, errs = 0;
  logic [3:0] pp_tab [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  wire [13:0] obs = {leds, step_idx, pass_cnt, running, done};

  led_sequencer #(.NUM_PASSES(3), .PASS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run_toggle(run_toggle), .step(step),
    .clear(clear), .dir(dir), .mode(mode), .leds(leds), .step_idx(step_idx),
    .pass_cnt(pass_cnt), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic [4:0] l, input int i, input int p, input logic r, input logic d);
    return {l, 3'(i), 4'(p), r, d};
  endfunction

  // stim bits: {run_toggle, tick, step, clear}
  task automatic apply(input logic [3:0] s);
    {run_toggle, tick, step, clear} = s;
    @(posedge clk);
    #1;
    {run_toggle, tick, step, clear} = '0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(14'd0);
    e = sb.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL reset_held got=%h exp=%h", obs, e); end
    @(negedge clk) rst_n = 1'b1;
    sb.push_back(14'd0);
    apply(4'b0000);
    e = sb.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL reset_idle got=%h exp=%h", obs, e); end
  endtask

  task automatic test_walk;
    mode = 2'd0; dir = 1'b1;
    sb.push_back(mk(5'b00001, 0, 0, 1, 0));
    apply(4'b1000);
    e = sb.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL walk_start got=%h exp=%h", obs, e); end
    for (int k = 1; k <= 8; k++) begin
      sb.push_back(mk({1'(k), 4'b0001 << (k % 4)}, k % 8, k / 8, 1, 0));
      apply(4'b0100);
      e = sb.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL walk k=%0d got=%h exp=%h", k, obs, e); end
    end
  endtask

  task automatic test_passes;
    sb.push_back(14'd0);
    apply(4'b0001);
    mode = 2'd2;
    sb.push_back(mk(5'b00001, 0, 0, 1, 0));
    apply(4'b1000);
    for (int k = 1; k <= 27; k++) begin
      sb.push_back(k < 24 ? mk({1'(k), pp_tab[k % 8]}, k % 8, k / 8, 1, 0) : mk(5'b10001, 7, 3, 0, 1));
      apply(4'b0100);
    end
    mode = 2'd0;
    sb.push_back(mk(5'b00001, 0, 0, 1, 0));
    apply(4'b1000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); vecs++;
      if (sb.size() == 0 && obs !== e) begin errs++; $display("FAIL passes_restart got=%h exp=%h", obs, e); end
    end
  endtask

  task automatic test_passes_stepwise;
    logic [3:0] s [2] = '{4'b0001, 4'b1000};
    mode = 2'd2;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(i == 0 ? 14'd0 : mk(5'b00001, 0, 0, 1, 0));
      apply(s[i]);
      e = sb.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL pp_start i=%0d got=%h exp=%h", i, obs, e); end
    end
    for (int k = 1; k <= 27; k++) begin
      sb.push_back(k < 24 ? mk({1'(k), pp_tab[k % 8]}, k % 8, k / 8, 1, 0) : mk(5'b10001, 7, 3, 0, 1));
      apply(4'b0100);
      e = sb.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL pingpong k=%0d got=%h exp=%h", k, obs, e); end
    end
    mode = 2'd0;
    sb.push_back(mk(5'b00001, 0, 0, 1, 0));
    apply(4'b1000);
    e = sb.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL done_restart got=%h exp=%h", obs, e); end
  endtask

  task automatic test_pause;
    logic [3:0] s [7] = '{4'b0100, 4'b0100, 4'b1100, 4'b0010, 4'b0010, 4'b0100, 4'b1010};
    logic [13:0] x [7] = '{mk(5'b10010, 1, 0, 1, 0), mk(5'b00100, 2, 0, 1, 0), mk(5'b00100, 2, 0, 0, 0),
                           mk(5'b11000, 3, 0, 0, 0), mk(5'b00001, 4, 0, 0, 0), mk(5'b00001, 4, 0, 0, 0),
                           mk(5'b00001, 4, 0, 1, 0)};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(x[i]);
      apply(s[i]);
      e = sb.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL pause i=%0d got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_reverse;
    logic [3:0] s [5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0100, 4'b0100};
    logic d [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [13:0] x [5] = '{14'd0, mk(5'b00000, 0, 0, 1, 0), mk(5'b10111, 7, 1, 1, 0),
                           mk(5'b00000, 0, 2, 1, 0), mk(5'b10000, 0, 3, 0, 1)};
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      dir = d[i];
      sb.push_back(x[i]);
      apply(s[i]);
      e = sb.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL reverse i=%0d got=%h exp=%h", i, obs, e); end
    end
    dir = 1'b1;
  endtask

  task automatic test_clear;
    logic [3:0] s [8] = '{4'b0001, 4'b1000, 4'b0100, 4'b1000, 4'b1001, 4'b1000, 4'b0100, 4'b0100};
    logic [1:0] m [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1};
    logic [13:0] x [8] = '{14'd0, mk(5'b00001, 0, 0, 1, 0), mk(5'b10010, 1, 0, 1, 0),
                           mk(5'b10010, 1, 0, 0, 0), 14'd0, mk(5'b01111, 0, 0, 1, 0),
                           mk(5'b10000, 1, 0, 1, 0), mk(5'b01111, 2, 0, 1, 0)};
    for (int i = 0; i < 8; i++) begin
      mode = m[i];
      sb.push_back(x[i]);
      apply(s[i]);
      e = sb.pop_front(); vecs++;
      if (obs !== e) begin errs++; $display("FAIL clear i=%0d got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_reset_async;
    sb.push_back(mk(5'b10000, 3, 0, 1, 0));
    apply(4'b0100);
    e = sb.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL pre_reset got=%h exp=%h", obs, e); end
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(14'd0);
    e = sb.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
    @(negedge clk) rst_n = 1'b1;
    sb.push_back(14'd0);
    apply(4'b0100);
    e = sb.pop_front(); vecs++;
    if (obs !== e) begin errs++; $display("FAIL post_reset got=%h exp=%h", obs, e); end
  endtask

  initial begin
    test_reset;
    test_walk;
    test_passes;
    test_passes_stepwise;
    test_pause;
    test_reverse;
    test_clear;
    test_reset_async;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
